// File: rtl/weight_control_pkg.sv
// Shared defaults for the cabin overload detector.
// Debounce sizing is only used when WEIGHT_DEBOUNCE_EN is defined.
package weight_control_pkg;

  localparam int LIMIT_DEF           = 5;
  localparam int CNT_W_DEF           = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int DB_CNT_W            =
    $clog2(DEBOUNCE_CYCLES_DEF + 1);

endpackage

// File: rtl/weight_control_if.sv
// Sensor, clear and status bundle of the overload detector.
// master drives the sensor/clear, slave is the detector.
interface weight_control_if
  import weight_control_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             weight_flip;
  logic             reset_weight_flip;
  logic             weight_limit_exceeded;
  logic [CNT_W-1:0] flip_count;

  modport master (
    output weight_flip,
    output reset_weight_flip,
    input  weight_limit_exceeded,
    input  flip_count
  );

  modport slave (
    input  weight_flip,
    input  reset_weight_flip,
    output weight_limit_exceeded,
    output flip_count
  );

endinterface

// File: rtl/weight_edge_detect.sv
// Synchronizer, optional debounce filter and rising-edge pulse.
// Filter present only when WEIGHT_DEBOUNCE_EN is defined.
module weight_edge_detect
  import weight_control_pkg::*;
`ifdef WEIGHT_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;
  logic lvl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

`ifdef WEIGHT_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DMAX =
    DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt;
  logic          filt;

  // filt follows sync2 only after it has differed for the full window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt <= '0;
      filt   <= 1'b0;
    end else if (sync2 != filt) begin
      if (db_cnt == DMAX) begin
        filt   <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= lvl;
  end

  assign rise = lvl & ~prev;

endmodule

// File: rtl/weight_control.sv
// Cabin overload detector: counts sensor rises, sticky flag at LIMIT.
// Define WEIGHT_DEBOUNCE_EN to insert the debounce filter.
module weight_control
  import weight_control_pkg::*;
#(
  parameter int LIMIT = LIMIT_DEF,
  parameter int CNT_W = CNT_W_DEF
`ifdef WEIGHT_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`endif
)(
  input  logic             clk,
  input  logic             rst_n,
  weight_control_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic             rise;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             flag_q;

  weight_edge_detect
`ifdef WEIGHT_DEBOUNCE_EN
  #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  )
`endif
  u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.weight_flip),
    .rise  (rise)
  );

  // saturate at LIM, never wrap
  always_comb begin
    cnt_nxt = cnt_q;
    if (rise && (cnt_q < LIM))
      cnt_nxt = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else if (bus.reset_weight_flip) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      flag_q <= (cnt_nxt >= LIM);
    end
  end

  assign bus.flip_count            = cnt_q;
  assign bus.weight_limit_exceeded = flag_q;

endmodule

// File: tb/tb_weight_control.sv
// Directed bench for weight_control, default and debounce builds.
`timescale 1ns/1ps
module tb_weight_control;

`ifdef WEIGHT_DEBOUNCE_EN
  localparam int DEB = 4;
  localparam int L   = DEB + 2;
  localparam int HI  = 8;
`else
  localparam int L   = 2;
  localparam int HI  = 3;
`endif
  localparam int REST = HI - L - 1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  weight_control_if bus ();

  weight_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.weight_flip = 1'b1;
    tick(HI);
    bus.weight_flip = 1'b0;
    tick(HI + L);
  endtask

  task automatic st(input string tag,
                    input int c, input int f);
    chk({tag, "_cnt"}, int'(bus.flip_count), c);
    chk({tag, "_flag"},
        int'(bus.weight_limit_exceeded), f);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.weight_flip       = 1'b0;
    bus.reset_weight_flip = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    st("reset", 0, 0);

    for (int i = 1; i <= 4; i++) begin
      pulse();
      st($sformatf("pulse%0d", i), i, 0);
    end

    bus.weight_flip = 1'b1;
    tick(L);
    st("lat_before", 4, 0);
    tick(1);
    st("lat_after", 5, 1);
    tick(REST);
    bus.weight_flip = 1'b0;
    tick(HI + L);

    pulse();
    st("sat6", 5, 1);
    pulse();
    st("sat7", 5, 1);

    bus.weight_flip = 1'b1;
    tick(L);
    bus.reset_weight_flip = 1'b1;
    tick(1);
    bus.reset_weight_flip = 1'b0;
    st("clr", 0, 0);
    tick(REST);
    bus.weight_flip = 1'b0;
    tick(HI + L);
    st("clr_drop", 0, 0);
    pulse();
    st("clr_next", 1, 0);

    bus.weight_flip = 1'b1;
    tick(20);
    bus.weight_flip = 1'b0;
    tick(HI + L);
    st("hold20", 2, 0);

    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    st("rst_mid", 0, 0);

    rst_n = 1'b0;
    bus.weight_flip = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(L + 2);
    st("hi_release", 1, 0);
    bus.weight_flip = 1'b0;
    tick(HI + L);

`ifdef WEIGHT_DEBOUNCE_EN
    bus.weight_flip = 1'b1;
    tick(2);
    bus.weight_flip = 1'b0;
    tick(12);
    st("glitch", 1, 0);

    bus.weight_flip = 1'b1;
    tick(L);
    st("db_before", 1, 0);
    bus.weight_flip = 1'b0;
    tick(1);
    st("db_after", 2, 0);
    tick(12);
    st("db_fall", 2, 0);
`endif

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
